// File: rtl/tl_cntr_rr.sv
// Round-robin traffic-light controller for NUM_DIR approaches with timed
// green/yellow/all-red phases, demand skipping and emergency preemption.

module tl_cntr_rr_lamp (
  input  logic [1:0] phase,
  input  logic       sel,
  output logic [1:0] lamp
);
  always_comb begin
    lamp = 2'b11;
    if (sel && phase == 2'b00) lamp = 2'b00;
    if (sel && phase == 2'b01) lamp = 2'b01;
  end
endmodule

module tl_cntr_rr #(
  parameter int NUM_DIR   = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int DIR_W     = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_DIR-1:0]     sensor,
  input  logic                   emerg,
  output logic [2*NUM_DIR-1:0]   lights,
  output logic [DIR_W-1:0]       active_dir,
  output logic [1:0]             phase
);
  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);

  phase_e               phase_q, phase_d;
  logic [DIR_W-1:0]     dir_q, dir_d;
  logic [CNT_W-1:0]     timer_q, timer_d;

  logic [NUM_DIR-1:0]   dir_oh;
  logic                 demand, own;
  logic [DIR_W-1:0]     nxt_dir;
  logic                 found;
  logic [NUM_DIR-1:0][1:0] lamp;

  always_comb begin
    dir_oh        = '0;
    dir_oh[dir_q] = 1'b1;
    demand        = |(sensor & ~dir_oh);
    own           = sensor[dir_q];
  end

  // Round-robin search starts just past the current owner and wraps; falls
  // back to the plain successor when nobody is waiting.
  always_comb begin
    nxt_dir = DIR_W'((int'(dir_q) + 1) % NUM_DIR);
    found   = 1'b0;
    for (int i = 1; i <= NUM_DIR; i++) begin
      int idx;
      idx = (int'(dir_q) + i) % NUM_DIR;
      if (!found && sensor[idx[DIR_W-1:0]]) begin
        nxt_dir = DIR_W'(idx);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    case (phase_q)
      PH_GREEN: begin
        if (timer_q < T_GMAX) timer_d = timer_q + 1'b1;
        if (emerg ||
            (demand && timer_q >= T_GMIN && (!own || timer_q >= T_GMAX))) begin
          phase_d = PH_YELLOW;
          timer_d = '0;
        end
      end
      PH_YELLOW: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == T_YEL) begin
          phase_d = PH_ALLRED;
          timer_d = '0;
        end
      end
      PH_ALLRED: begin
        if (emerg) begin
          timer_d = '0;
        end else if (timer_q >= T_AR) begin
          phase_d = PH_GREEN;
          timer_d = '0;
          dir_d   = nxt_dir;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        phase_d = PH_GREEN;
        timer_d = '0;
        dir_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_GREEN;
      dir_q   <= '0;
      timer_q <= '0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  for (genvar k = 0; k < NUM_DIR; k++) begin : g_lamp
    tl_cntr_rr_lamp u_lamp (
      .phase (phase_q),
      .sel   (dir_q == DIR_W'(k)),
      .lamp  (lamp[k])
    );
  end

  assign lights     = lamp;
  assign active_dir = dir_q;
  assign phase      = phase_q;
endmodule

// File: doc/tl_cntr_rr.md
Name: tl_cntr_rr

Overview:
- Parametrised successor to the two-road traffic-light FSM, for NUM_DIR approaches served round-robin.
- Adds timed phases: minimum and maximum green, fixed yellow and all-red clearance, plus demand-skipping and emergency preemption.
- Sits between the synchronised vehicle-sensor inputs and the lamp drivers.

Parameters:
- NUM_DIR, 4, number of approaches (2..16)
- CNT_W, 8, phase timer width; GREEN_MAX must be <= 2**CNT_W
- GREEN_MIN, 4, minimum green cycles (>=1)
- GREEN_MAX, 12, maximum green cycles under competing demand (>= GREEN_MIN)
- YELLOW_T, 2, yellow cycles (>=1)
- ALLRED_T, 1, all-red clearance cycles (>=1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- sensor  in  NUM_DIR  bit k = vehicle waiting on approach k
- emerg  in  1  emergency preempt request, level-sensitive
- lights  out  2*NUM_DIR  lights[2k+1:2k] = lamp of approach k; GREEN=2'b00, YELLOW=2'b01, RED=2'b11
- active_dir  out  DIR_W=max(1,$clog2(NUM_DIR))  approach owning the current green/yellow
- phase  out  2  2'b00 GREEN, 2'b01 YELLOW, 2'b10 ALLRED

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state (phase, active_dir, timer) is registered. lights, active_dir and phase are decoded only from registers (Moore).
- Reset, sampled at posedge: phase=GREEN, active_dir=0, timer=0. lights: approach 0 = GREEN, all others = RED.
- Reset mid-operation from any state gives the same result on the next edge.
- Lamp decode:
  - GREEN phase: active_dir = GREEN, others RED.
  - YELLOW phase: active_dir = YELLOW, others RED.
  - ALLRED phase: all approaches RED.
  - A lamp value of 2'b10 is never driven.
- demand = OR of sensor[k] for all k != active_dir.
- GREEN phase:
  - timer increments each cycle, saturating at GREEN_MAX-1.
  - Exit to YELLOW (timer<=0) at the edge where either:
    (a) emerg=1 (ignores GREEN_MIN), or
    (b) demand=1 AND timer>=GREEN_MIN-1 AND (sensor[active_dir]=0 OR timer>=GREEN_MAX-1).
  - With demand=0 and emerg=0, green holds indefinitely.
  - Resulting green length:
    - GREEN_MIN cycles if the own approach is empty and demand is present;
    - GREEN_MAX cycles if the own approach stays occupied.
- YELLOW phase:
  - Lasts exactly YELLOW_T cycles; emerg does not shorten it.
  - Then goes to ALLRED with timer<=0.
- ALLRED phase:
  - While emerg=1, timer is held at 0 and the phase holds.
  - Otherwise timer counts; after ALLRED_T cycles with emerg=0, the phase goes to GREEN with timer<=0.
  - The new active_dir is the first k, searching active_dir+1, active_dir+2, ... modulo NUM_DIR, with sensor[k]=1, sampled on the exit edge.
  - If no sensor is set, the new active_dir is (active_dir+1) mod NUM_DIR.
  - Wrap from NUM_DIR-1 to 0 is required.
- Simultaneous events:
  - reset has priority over everything.
  - In GREEN, emerg has priority over the timer rules.
  - Sensor changes during YELLOW/ALLRED affect only the next-direction choice at the ALLRED exit edge.
- Counter widths: timer is CNT_W bits; comparisons are unsigned; no overflow is possible given the parameter constraints.
- Exactly one approach is ever non-RED, and never during ALLRED. The bench asserts this every cycle.

Test Plan:
- Reset: hold reset=1 for 2 cycles with sensor=4'b1111, then release, sensor=0 -> lights=8'b11111100, phase=00, active_dir=0. Holds GREEN for 50 cycles with no demand.
- Min green + skip: after reset, sensor=4'b0100 constant -> approach 0 GREEN for 4 cycles, YELLOW 2, ALLRED 1, then active_dir=2 GREEN (approach 1 skipped).
- Max green: after reset, sensor=4'b0011 constant -> approach 0 GREEN for exactly 12 cycles, YELLOW 2, ALLRED 1, then active_dir=1.
- Emergency: at approach 1 GREEN timer=1, emerg=1 for 10 cycles -> YELLOW next cycle for 2 cycles, then ALLRED held until emerg falls. Then exactly 1 more ALLRED cycle, then next green per round-robin.
- Wrap: force active_dir=3 GREEN (via sequence), sensor=4'b0001 -> after YELLOW/ALLRED, active_dir=0. With sensor=0, after emerg-forced clearance, active_dir=0 (default next).
- Reset mid-YELLOW: assert reset during YELLOW of approach 2 -> next edge phase=GREEN, active_dir=0, timer=0, lights=8'b11111100.
